zx_vram_port: RTL and testbench

- Responder side of the screen-memory fetch interface used by the 640x480 scanout block.
- Owns the single-port 16K x 8 video BRAM and answers the scanout's address/data fetches with fixed timing.
- Interleaves Z80-side accesses in cycles the scanout leaves free: posted writes go through a 4-entry FIFO, and reads block until they complete.

---
 rtl/zx_vram_port_if.sv | 31 +++
 rtl/zx_vram_port.sv | 146 ++++++++++++++
 tb/tb_zx_vram_port.sv | 388 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zx_vram_port_if.sv
// -----------------------------------------------------------------------------
// zx_vram_port_if
// CPU-side access bus of the video RAM port.
//   cpu_req   : access request, level, held by the CPU until cpu_ack
//   cpu_we    : 1 = write, 0 = read (qualified by cpu_req)
//   cpu_addr  : byte address in video memory
//   cpu_wdata : write data
//   cpu_ack   : one-cycle completion pulse from the port
//   cpu_rdata : read data, valid while cpu_ack is high
// master = CPU side, slave = zx_vram_port.
// -----------------------------------------------------------------------------
interface zx_vram_port_if #(
    parameter int AW = 14
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/zx_vram_port.sv
// -----------------------------------------------------------------------------
// zx_vram_port
// Owns the single-port 16K x 8 video BRAM. The scanout gets the port whenever
// it asserts vid_busy, with fixed one-cycle read latency. CPU writes are posted
// into a small FIFO and drained in free cycles; CPU reads wait for the FIFO to
// empty (so they observe all earlier writes) and then use the next free cycle.
//
// Ports:
//   clock, reset : pixel clock, synchronous active-high reset
//   vid_addr     : scanout fetch address
//   vid_busy     : scanout owns the BRAM this cycle
//   vid_data     : fetched byte (mem_rdata, one cycle after vid_addr)
//   cpu          : CPU access bus (zx_vram_port_if.slave)
//   mem_addr     : BRAM address
//   mem_wdata    : BRAM write data
//   mem_we       : BRAM write enable
//   mem_rdata    : BRAM read data, one cycle after mem_addr is sampled
// -----------------------------------------------------------------------------
module zx_vram_port #(
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] vid_addr,
    input  logic          vid_busy,
    output logic [7:0]    vid_data,
    zx_vram_port_if.slave cpu,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata
);

    localparam int            PW         = $clog2(FIFO_DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_WAIT
    } state_t;

    state_t        state;
    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]    fifo_data [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          ack_q;
    logic [7:0]    rdata_q;

    logic fifo_full;
    logic fifo_empty;
    logic issue_rd;
    logic push;
    logic pop;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        fifo_full  = (count == FULL_COUNT);
        fifo_empty = (count == '0);
        issue_rd   = (state == RD_ISSUE) && !vid_busy;
        // The request seen in an ack cycle is the one just served: ignore it.
        push       = cpu.cpu_req && cpu.cpu_we && !fifo_full &&
                     (state == IDLE) && !ack_q;
        pop        = !reset && !vid_busy && !fifo_empty && !issue_rd;
    end

    // BRAM port mux: video always wins; otherwise a drain or a read issue.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (vid_busy) begin
            mem_addr = vid_addr;
        end else if (pop) begin
            mem_addr  = fifo_addr[rd_ptr];
            mem_wdata = fifo_data[rd_ptr];
            mem_we    = 1'b1;
        end else if (issue_rd) begin
            mem_addr = cpu.cpu_addr;
        end
    end

    assign vid_data    = mem_rdata;
    assign cpu.cpu_ack = ack_q;
    // In RD_WAIT the BRAM output is already the requested byte, so pass it
    // through during the ack cycle and hold the captured copy afterwards.
    assign cpu.cpu_rdata = (state == RD_WAIT) ? mem_rdata : rdata_q;

    // NOTE: FIFO storage is deliberately left out of reset; occupancy is
    // tracked by count/pointers, so stale entries are never read.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr[wr_ptr] <= cpu.cpu_addr;
            fifo_data[wr_ptr] <= cpu.cpu_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            // Write acks follow the push; read acks coincide with RD_WAIT.
            ack_q <= push || issue_rd;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (cpu.cpu_req && !cpu.cpu_we && !ack_q) state <= RD_DRAIN;
                end
                RD_DRAIN: begin
                    // Reads must observe every earlier posted write.
                    if (fifo_empty) state <= RD_ISSUE;
                end
                RD_ISSUE: begin
                    if (!vid_busy) state <= RD_WAIT;
                end
                RD_WAIT: begin
                    rdata_q <= mem_rdata;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_zx_vram_port.sv
// -----------------------------------------------------------------------------
// tb_zx_vram_port
// Bench for zx_vram_port. Holds a behavioural BRAM, a CPU-visible memory image
// (updated on each acked write) and a queue of acked writes that must appear
// on the BRAM port in order. A negedge monitor checks video fetch data and
// every BRAM write; scenario tasks check timing and read data.
// -----------------------------------------------------------------------------
module tb_zx_vram_port;

    localparam int AW = 14;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] vid_addr;
    logic          vid_busy;
    logic [7:0]    vid_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_we;
    logic [7:0]    mem_rdata;

    zx_vram_port_if #(.AW(AW)) cpu_bus ();

    zx_vram_port #(.FIFO_DEPTH(4), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .vid_addr  (vid_addr),
        .vid_busy  (vid_busy),
        .vid_data  (vid_data),
        .cpu       (cpu_bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            drain_count = 0;
    logic [7:0]    bram     [1<<AW];
    logic [7:0]    cpu_view [1<<AW];
    wr_t           exp_q [$];
    logic          preload_en;
    logic [AW-1:0] preload_addr;
    logic [7:0]    preload_data;
    bit            pattern_on = 0;
    bit            rand_on = 0;

    // Behavioural single-port BRAM, read-before-write, one-cycle latency.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (preload_en)  bram[preload_addr] <= preload_data;
        else if (mem_we) bram[mem_addr]     <= mem_wdata;
        mem_rdata <= bram[mem_addr];
    end

    // Monitor: video data and BRAM write ordering.
    initial begin : monitor
        logic       vid_pend;
        logic [7:0] vid_exp;
        wr_t        e;
        vid_pend = 1'b0;
        vid_exp  = '0;
        forever begin
            @(negedge clock);
            if (vid_pend) begin
                checks++;
                if (vid_data !== vid_exp) begin
                    errors++;
                    $display("FAIL vid_data: got %h expected %h (cycle %0d)", vid_data, vid_exp, cyc);
                end
            end
            vid_pend = vid_busy;
            vid_exp  = bram[vid_addr];
            if (mem_we) begin
                checks++;
                if (vid_busy || exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain: unexpected write %h<=%h busy=%b queued=%0d", mem_addr, mem_wdata, vid_busy, exp_q.size());
                end else begin
                    e = exp_q.pop_front();
                    if (mem_addr !== e.a || mem_wdata !== e.d) begin
                        errors++;
                        $display("FAIL drain_order: got %h<=%h expected %h<=%h", mem_addr, mem_wdata, e.a, e.d);
                    end
                end
                drain_count++;
            end
        end
    end

    initial begin : watchdog
        repeat (60000) @(posedge clock);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Starts a write in the current cycle; returns cycles to ack or -1.
    task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d, input int budget, output int lat);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = d;
        lat = -1;
        for (int k = 1; k <= budget; k++) begin
            step(1);
            if (cpu_bus.cpu_ack === 1'b1) begin
                lat = k;
                break;
            end
        end
        if (lat > 0) begin
            exp_q.push_back({a, d});
            cpu_view[a] = d;
        end
        cpu_bus.cpu_req = 1'b0;
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input int budget, output int lat, output logic [7:0] data);
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = a;
        lat  = -1;
        data = '0;
        for (int k = 1; k <= budget; k++) begin
            step(1);
            if (cpu_bus.cpu_ack === 1'b1) begin
                lat  = k;
                data = cpu_bus.cpu_rdata;
                break;
            end
        end
        cpu_bus.cpu_req = 1'b0;
    endtask

    task automatic vid_pattern();
        int ph = 0;
        while (pattern_on) begin
            step(1);
            vid_busy = (ph < 2);
            vid_addr = AW'($urandom);
            ph = (ph + 1) % 16;
        end
    endtask

    task automatic vid_random();
        while (rand_on) begin
            step(1);
            vid_busy = ($urandom_range(0, 9) < 3);
            vid_addr = AW'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        @(negedge clock);
        checks++; if (cpu_bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", cpu_bus.cpu_ack); end
        checks++; if (cpu_bus.cpu_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", cpu_bus.cpu_rdata); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 00", mem_wdata); end
        step(1);
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_video();
        preload_en = 1'b1; preload_addr = 14'h1000; preload_data = 8'hA5;
        step(1);
        preload_en = 1'b0;
        vid_busy = 1'b1; vid_addr = 14'h1000;
        @(negedge clock);
        checks++; if (mem_addr !== 14'h1000 || mem_we !== 1'b0) begin errors++; $display("FAIL video_port: got addr %h we %b expected 1000 0", mem_addr, mem_we); end
        step(1);
        vid_busy = 1'b0;
        @(negedge clock);
        checks++; if (vid_data !== 8'hA5) begin errors++; $display("FAIL video_data: got %h expected a5", vid_data); end
        step(1);
    endtask

    task automatic test_single_write();
        int lat;
        logic [7:0] rd_before;
        vid_busy = 1'b0;
        step(1);
        rd_before = cpu_bus.cpu_rdata;
        cpu_write(14'h1800, 8'h3C, 8, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL write_ack_latency: got %0d expected 1", lat); end
        @(negedge clock);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 14'h1800 || mem_wdata !== 8'h3C) begin errors++; $display("FAIL write_drain: got we %b %h<=%h expected 1 1800<=3c", mem_we, mem_addr, mem_wdata); end
        checks++; if (cpu_bus.cpu_rdata !== rd_before) begin errors++; $display("FAIL write_rdata_hold: got %h expected %h", cpu_bus.cpu_rdata, rd_before); end
        step(3);
    endtask

    task automatic test_read_stall();
        int lat;
        logic [7:0] data;
        vid_busy = 1'b0; vid_addr = 14'h1000;
        step(2);
        cpu_read(14'h1800, 10, lat, data);
        checks++; if (lat != 3) begin errors++; $display("FAIL read_min_latency: got %0d expected 3", lat); end
        checks++; if (data !== cpu_view[14'h1800]) begin errors++; $display("FAIL read_min_data: got %h expected %h", data, cpu_view[14'h1800]); end
        step(2);
        // Video takes the two cycles in which the read would issue.
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 14'h1800;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            vid_busy = (k == 2 || k == 3);
            if (k == 4) begin
                @(negedge clock);
                checks++; if (mem_addr !== 14'h1800 || mem_we !== 1'b0) begin errors++; $display("FAIL read_issue: got addr %h we %b expected 1800 0", mem_addr, mem_we); end
            end
            if (cpu_bus.cpu_ack === 1'b1) begin
                lat = k; data = cpu_bus.cpu_rdata;
                break;
            end
        end
        cpu_bus.cpu_req = 1'b0; vid_busy = 1'b0;
        checks++; if (lat != 5) begin errors++; $display("FAIL read_stall_latency: got %0d expected 5", lat); end
        checks++; if (data !== cpu_view[14'h1800]) begin errors++; $display("FAIL read_stall_data: got %h expected %h", data, cpu_view[14'h1800]); end
        step(2);
    endtask

    task automatic test_fifo_full();
        int lat;
        int acks;
        int d0;
        int m;
        vid_busy = 1'b1; vid_addr = 14'h0ABC;
        step(1);
        for (int i = 0; i < 4; i++) begin
            cpu_write(AW'(14'h2000 + i), 8'(8'h10 + i), 4, lat);
            checks++; if (lat < 0) begin errors++; $display("FAIL full_ack%0d: got no ack expected ack", i); end
        end
        // Fifth write: FIFO is full, so it must be held.
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b1;
        cpu_bus.cpu_addr = 14'h2004; cpu_bus.cpu_wdata = 8'h14;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            if (cpu_bus.cpu_ack === 1'b1) acks++;
        end
        checks++; if (acks != 0) begin errors++; $display("FAIL full_hold: got %0d acks expected 0", acks); end
        vid_busy = 1'b0;
        d0 = drain_count; m = cyc;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (cpu_bus.cpu_ack === 1'b1) begin lat = k; break; end
        end
        cpu_bus.cpu_req = 1'b0;
        // First pop frees a slot; the push lands one cycle later, ack after that.
        checks++; if (lat != 2) begin errors++; $display("FAIL full_release_ack: got %0d expected 2 (cycle %0d)", lat, m); end
        checks++; if (drain_count - d0 != 2) begin errors++; $display("FAIL full_drains_at_ack: got %0d expected 2", drain_count - d0); end
        if (lat > 0) begin exp_q.push_back({14'h2004, 8'h14}); cpu_view[14'h2004] = 8'h14; end
        step(4);
        checks++; if (drain_count - d0 != 5 || exp_q.size() != 0) begin errors++; $display("FAIL full_drain_total: got %0d drains, %0d queued expected 5, 0", drain_count - d0, exp_q.size()); end
    endtask

    task automatic test_read_after_write();
        int lat;
        logic [7:0] data;
        pattern_on = 1;
        fork vid_pattern(); join_none
        step(1);
        for (int i = 0; i < 3; i++) begin
            cpu_write(AW'(14'h0200 + i), 8'($urandom), 40, lat);
            checks++; if (lat < 0) begin errors++; $display("FAIL raw_pre_ack%0d: got no ack expected ack", i); end
        end
        cpu_write(14'h0100, 8'h77, 40, lat);
        checks++; if (lat < 0) begin errors++; $display("FAIL raw_write_ack: got no ack expected ack"); end
        cpu_read(14'h0100, 60, lat, data);
        checks++; if (lat < 0 || exp_q.size() != 0) begin errors++; $display("FAIL raw_order: got lat %0d, %0d writes pending expected ack after drain", lat, exp_q.size()); end
        checks++; if (data !== 8'h77) begin errors++; $display("FAIL raw_data: got %h expected 77", data); end
        pattern_on = 0;
        step(2);
        vid_busy = 1'b0;
        step(2);
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [8];
        int lat;
        logic [7:0] data;
        int idx;
        pool[0] = 14'h0000;
        pool[1] = 14'h3FFF;
        for (int i = 2; i < 8; i++) pool[i] = AW'($urandom_range(0, 14'h0FFF));
        rand_on = 1;
        fork vid_random(); join_none
        step(1);
        for (int i = 0; i < 8; i++) begin
            cpu_write(pool[i], 8'($urandom), 200, lat);
            checks++; if (lat < 0) begin errors++; $display("FAIL rand_init_ack%0d: got no ack expected ack", i); end
        end
        for (int n = 0; n < 80; n++) begin
            idx = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                cpu_write(pool[idx], 8'($urandom), 200, lat);
                checks++; if (lat < 0) begin errors++; $display("FAIL rand_write_ack%0d: got no ack expected ack", n); end
            end else begin
                cpu_read(pool[idx], 200, lat, data);
                checks++; if (lat < 0 || exp_q.size() != 0) begin errors++; $display("FAIL rand_read_order%0d: got lat %0d, %0d pending expected ack after drain", n, lat, exp_q.size()); end
                checks++; if (data !== cpu_view[pool[idx]]) begin errors++; $display("FAIL rand_read_data%0d: addr %h got %h expected %h", n, pool[idx], data, cpu_view[pool[idx]]); end
            end
            step($urandom_range(0, 2));
        end
        rand_on = 0;
        step(2);
        vid_busy = 1'b0;
        step(6);
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rand_final_drain: got %0d pending expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int lat;
        int we_seen;
        int ack_seen;
        logic [7:0] data;
        vid_busy = 1'b1; vid_addr = 14'h0123;
        step(1);
        for (int i = 0; i < 3; i++) begin
            cpu_write(AW'(14'h3A00 + i), 8'(8'hC0 + i), 4, lat);
            checks++; if (lat < 0) begin errors++; $display("FAIL rmid_ack%0d: got no ack expected ack", i); end
        end
        cpu_bus.cpu_req = 1'b1; cpu_bus.cpu_we = 1'b0; cpu_bus.cpu_addr = 14'h3A00;
        step(3);
        reset = 1'b1; cpu_bus.cpu_req = 1'b0;
        exp_q.delete();
        step(1);
        reset = 1'b0; vid_busy = 1'b0;
        we_seen = 0; ack_seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (mem_we === 1'b1) we_seen++;
            if (cpu_bus.cpu_ack === 1'b1) ack_seen++;
        end
        checks++; if (we_seen != 0) begin errors++; $display("FAIL rmid_no_write: got %0d writes expected 0", we_seen); end
        checks++; if (ack_seen != 0) begin errors++; $display("FAIL rmid_no_ack: got %0d acks expected 0", ack_seen); end
        step(1);
        // An empty FIFO gives the minimum read latency.
        cpu_read(14'h1800, 10, lat, data);
        checks++; if (lat != 3) begin errors++; $display("FAIL rmid_fifo_empty: got latency %0d expected 3", lat); end
        checks++; if (data !== cpu_view[14'h1800]) begin errors++; $display("FAIL rmid_read_data: got %h expected %h", data, cpu_view[14'h1800]); end
        step(2);
    endtask

    initial begin
        reset = 1'b1;
        vid_busy = 1'b0;
        vid_addr = '0;
        preload_en = 1'b0;
        preload_addr = '0;
        preload_data = '0;
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we = 1'b0;
        cpu_bus.cpu_addr = '0;
        cpu_bus.cpu_wdata = '0;
        test_reset();
        test_video();
        test_single_write();
        test_read_stall();
        test_fifo_full();
        test_read_after_write();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
